// File: rtl/datapath.sv
// Phase-1 bus-based 32-bit CPU datapath: shared bus, PC/IR/MAR/MDR/Y/Z and R2/R4/R5 around a combinational ALU.
// Optional DATAPATH_MULDIV_EN adds signed MUL (01010) and DIV (01011) to the ALU.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] MData_In,
  input  logic [4:0]       CONTROL,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             PC_Out,
  input  logic             MDR_Out,
  input  logic             ZLO_Out,
  input  logic             R2_Out,
  input  logic             R4_Out,
  input  logic             PC_In,
  input  logic             MDR_In,
  input  logic             MAR_In,
  input  logic             IR_In,
  input  logic             Y_In,
  input  logic             ZLO_In,
  input  logic             R2_In,
  input  logic             R4_In,
  input  logic             R5_In,
  output logic [WIDTH-1:0] BusMux_Out
);

  typedef enum logic [4:0] {
    OP_ADD = 5'b00000,
    OP_SUB = 5'b00001,
    OP_AND = 5'b00010,
    OP_OR  = 5'b00011,
    OP_SHR = 5'b00100,
    OP_SHL = 5'b00101,
    OP_ROR = 5'b00110,
    OP_ROL = 5'b00111,
    OP_NEG = 5'b01000,
    OP_NOT = 5'b01001,
    OP_MUL = 5'b01010,
    OP_DIV = 5'b01011
  } alu_op_e;

  logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [WIDTH-1:0]   y_q, y_d, r2_q, r2_d, r4_q, r4_d, r5_q, r5_d;
  logic [2*WIDTH-1:0] z_q, z_d;
  logic [2*WIDTH-1:0] alu_c, rot_r, rot_l;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [4:0]         shamt;

  // Fixed-priority bus source select; R5, IR, MAR and ZHI never drive the bus.
  always_comb begin
    if (PC_Out)       BusMux_Out = pc_q;
    else if (MDR_Out) BusMux_Out = mdr_q;
    else if (ZLO_Out) BusMux_Out = z_q[WIDTH-1:0];
    else if (R2_Out)  BusMux_Out = r2_q;
    else if (R4_Out)  BusMux_Out = r4_q;
    else              BusMux_Out = '0;
  end

  assign alu_a = y_q;
  assign alu_b = BusMux_Out;
  assign shamt = alu_b[4:0];
  // Rotates shift a doubled copy so the wrapped bits land in the kept half.
  assign rot_r = {alu_a, alu_a} >> shamt;
  assign rot_l = {alu_a, alu_a} << shamt;

  always_comb begin
    alu_c = '0;
    if (IncPC) begin
      alu_c[WIDTH-1:0] = alu_b + 1'b1;
    end else begin
      case (CONTROL)
        OP_ADD: alu_c[WIDTH-1:0] = alu_a + alu_b;
        OP_SUB: alu_c[WIDTH-1:0] = alu_a - alu_b;
        OP_AND: alu_c[WIDTH-1:0] = alu_a & alu_b;
        OP_OR:  alu_c[WIDTH-1:0] = alu_a | alu_b;
        OP_SHR: alu_c[WIDTH-1:0] = alu_a >> shamt;
        OP_SHL: alu_c[WIDTH-1:0] = alu_a << shamt;
        OP_ROR: alu_c[WIDTH-1:0] = rot_r[WIDTH-1:0];
        OP_ROL: alu_c[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
        OP_NEG: alu_c[WIDTH-1:0] = -alu_b;
        OP_NOT: alu_c[WIDTH-1:0] = ~alu_b;
`ifdef DATAPATH_MULDIV_EN
        OP_MUL: alu_c = $signed(alu_a) * $signed(alu_b);
        OP_DIV: if (alu_b != '0)
                  alu_c = {WIDTH'($signed(alu_a) % $signed(alu_b)),
                           WIDTH'($signed(alu_a) / $signed(alu_b))};
`endif
        default: alu_c = '0;
      endcase
    end
  end

  always_comb begin
    pc_d  = PC_In  ? BusMux_Out : pc_q;
    ir_d  = IR_In  ? BusMux_Out : ir_q;
    mar_d = MAR_In ? BusMux_Out : mar_q;
    mdr_d = mdr_q;
    if (MDR_In) mdr_d = Read ? MData_In : BusMux_Out;
    y_d   = Y_In   ? BusMux_Out : y_q;
    z_d   = ZLO_In ? alu_c      : z_q;
    r2_d  = R2_In  ? BusMux_Out : r2_q;
    r4_d  = R4_In  ? BusMux_Out : r4_q;
    r5_d  = R5_In  ? BusMux_Out : r5_q;
  end

  // NOTE: non-blocking assignments let a register drive its old value onto the
  // bus in the same cycle it loads, which the transfer timing depends on.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      r2_q  <= '0;
      r4_q  <= '0;
      r5_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      z_q   <= z_d;
      r2_q  <= r2_d;
      r4_q  <= r4_d;
      r5_q  <= r5_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: expected values are queued when a step is driven and compared when the result appears.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] MData_In;
  logic [4:0]  CONTROL;
  logic        IncPC, Read;
  logic        PC_Out, MDR_Out, ZLO_Out, R2_Out, R4_Out;
  logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R2_In, R4_In, R5_In;
  logic [31:0] BusMux_Out;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  datapath dut (
    .Clock(Clock), .Clear(Clear), .MData_In(MData_In), .CONTROL(CONTROL),
    .IncPC(IncPC), .Read(Read),
    .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out), .R2_Out(R2_Out), .R4_Out(R4_Out),
    .PC_In(PC_In), .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
    .ZLO_In(ZLO_In), .R2_In(R2_In), .R4_In(R4_In), .R5_In(R5_In),
    .BusMux_Out(BusMux_Out)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle();
    CONTROL = 5'b0; IncPC = 0; Read = 0; MData_In = '0;
    PC_Out = 0; MDR_Out = 0; ZLO_Out = 0; R2_Out = 0; R4_Out = 0;
    PC_In = 0; MDR_In = 0; MAR_In = 0; IR_In = 0; Y_In = 0; ZLO_In = 0;
    R2_In = 0; R4_In = 0; R5_In = 0;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic got(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic load_mdr(input logic [31:0] v);
    MData_In = v; Read = 1; MDR_In = 1;
    step();
  endtask

  // Y already loaded; MDR supplies B. Result is checked through ZLO on the bus.
  task automatic alu_op(input string tag, input logic [4:0] op, input logic [31:0] exp);
    MDR_Out = 1; CONTROL = op; ZLO_In = 1;
    expect_val(tag, exp);
    step();
    ZLO_Out = 1;
    #1 got(BusMux_Out);
    step();
  endtask

  initial begin
    idle();
    Clear = 0;
    step(); step();
    expect_val("reset_pc",  32'h0); PC_Out = 1;  #1 got(BusMux_Out); idle();
    expect_val("reset_mdr", 32'h0); MDR_Out = 1; #1 got(BusMux_Out); idle();
    expect_val("reset_zlo", 32'h0); ZLO_Out = 1; #1 got(BusMux_Out); idle();
    Clear = 1;
    step();

    // Memory read into MDR, then MDR -> R2.
    load_mdr(32'hE000_0000);
    MDR_Out = 1; R2_In = 1;
    expect_val("mdr_to_bus", 32'hE000_0000);
    #1 got(BusMux_Out);
    step();
    R2_Out = 1;
    expect_val("r2_loaded", 32'hE000_0000);
    #1 got(BusMux_Out);
    step();

    // MDR_In=0 holds MDR even with Read asserted.
    MData_In = 32'h1234_5678; Read = 1;
    step();
    MDR_Out = 1;
    expect_val("mdr_hold", 32'hE000_0000);
    #1 got(BusMux_Out);
    step();

    // Same-cycle drive and load: old value on bus, new after edge.
    MDR_Out = 1; MDR_In = 1; Read = 1; MData_In = 32'hA5A5_0001;
    expect_val("drive_load_old", 32'hE000_0000);
    #1 got(BusMux_Out);
    step();
    MDR_Out = 1;
    expect_val("drive_load_new", 32'hA5A5_0001);
    #1 got(BusMux_Out);
    step();

    // R4 = 5, R5 = 32 (to be overwritten), then ROR R2 by R4 into R5.
    load_mdr(32'd5);  MDR_Out = 1; R4_In = 1; step();
    load_mdr(32'd32); MDR_Out = 1; R5_In = 1; step();
    R2_Out = 1; Y_In = 1; step();
    R4_Out = 1; CONTROL = 5'b00110; ZLO_In = 1; step();
    ZLO_Out = 1; R5_In = 1;
    expect_val("ror_bus", 32'h0700_0000);
    #1 got(BusMux_Out);
    step();
    expect_val("ror_r5", 32'h0700_0000);
    got(dut.r5_q);

    // PC increment through Z; MAR captures the old PC.
    PC_Out = 1; MAR_In = 1; IncPC = 1; ZLO_In = 1; CONTROL = 5'b00001;
    step();
    expect_val("inc_mar", 32'h0);
    got(dut.mar_q);
    expect_val("inc_zhi", 32'h0);
    got(dut.z_q[63:32]);
    ZLO_Out = 1; PC_In = 1; step();
    PC_Out = 1;
    expect_val("pc_inc", 32'h1);
    #1 got(BusMux_Out);
    step();

    // PC wrap from all ones.
    load_mdr(32'hFFFF_FFFF); MDR_Out = 1; PC_In = 1; step();
    PC_Out = 1; IncPC = 1; ZLO_In = 1; step();
    ZLO_Out = 1;
    expect_val("pc_wrap", 32'h0);
    #1 got(BusMux_Out);
    step();

    // Shift/rotate and logic ops with Y=0x80000001, B=1.
    load_mdr(32'h8000_0001); MDR_Out = 1; Y_In = 1; step();
    load_mdr(32'd1);
    alu_op("shr", 5'b00100, 32'h4000_0000);
    alu_op("shl", 5'b00101, 32'h0000_0002);
    alu_op("rol", 5'b00111, 32'h0000_0003);
    alu_op("ror1", 5'b00110, 32'hC000_0000);
    alu_op("add", 5'b00000, 32'h8000_0002);
    alu_op("sub", 5'b00001, 32'h8000_0000);
    alu_op("and", 5'b00010, 32'h0000_0001);
    alu_op("or",  5'b00011, 32'h8000_0001);
    alu_op("neg", 5'b01000, 32'hFFFF_FFFF);
    alu_op("not", 5'b01001, 32'hFFFF_FFFE);
`ifndef DATAPATH_MULDIV_EN
    alu_op("unused_mul", 5'b01010, 32'h0);
`endif
    alu_op("unused_1f", 5'b11111, 32'h0);
    load_mdr(32'd32);
    alu_op("ror_by_32", 5'b00110, 32'h8000_0001);
    alu_op("shl_by_32", 5'b00101, 32'h8000_0001);

    // Bus priority: PC wins over R2; nothing enabled reads zero.
    load_mdr(32'h1234_5678); MDR_Out = 1; PC_In = 1; step();
    PC_Out = 1; R2_Out = 1;
    expect_val("prio_pc_r2", 32'h1234_5678);
    #1 got(BusMux_Out);
    idle();
    MDR_Out = 1; ZLO_Out = 1; R4_Out = 1;
    expect_val("prio_mdr_zlo", 32'h1234_5678);
    #1 got(BusMux_Out);
    idle();
    ZLO_Out = 1; R2_Out = 1;
    expect_val("prio_zlo_r2", 32'h8000_0001);
    #1 got(BusMux_Out);
    idle();
    expect_val("bus_idle", 32'h0);
    #1 got(BusMux_Out);

    // Asynchronous clear pulse mid-cycle.
    #2 Clear = 0;
    #1;
    expect_val("clr_pc",  32'h0); PC_Out = 1;  #1 got(BusMux_Out); idle();
    expect_val("clr_mdr", 32'h0); MDR_Out = 1; #1 got(BusMux_Out); idle();
    expect_val("clr_zlo", 32'h0); ZLO_Out = 1; #1 got(BusMux_Out); idle();
    expect_val("clr_r2",  32'h0); R2_Out = 1;  #1 got(BusMux_Out); idle();
    expect_val("clr_r4",  32'h0); R4_Out = 1;  #1 got(BusMux_Out); idle();
    expect_val("clr_r5",  32'h0); got(dut.r5_q);
    expect_val("clr_y",   32'h0); got(dut.y_q);
    step();
    Clear = 1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
